mem_arbiter: RTL and testbench

- Two-client arbiter that sits directly downstream of the instruction and data caches and drives the single main-memory port.
- Accepts one cache-line-beat transaction at a time, either an icache read or a dcache read/write, and forwards it to memory.
- For reads, holds ownership until all RESP_BEATS response beats have been routed back to the requester.
- Client-side and memory-side signalling match the caches' existing mem_req/mem_resp interface.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 67 ++++++
 rtl/mem_arb_grant.sv | 38 +++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-client memory arbiter.
// Build with ARB_RR_EN defined for round-robin grant; default is fixed dcache priority.
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 28;
    localparam int DEF_DATA_W     = 128;
    localparam int DEF_RESP_BEATS = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IC,
        OWN_DC
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side request/response bundle of the arbiter.
// slave is the arbiter's view; master is the caches/memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);
    localparam int MASK_W = DATA_W / 8;

    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid;
    logic [DATA_W-1:0] ic_resp_data;

    logic              dc_req_valid;
    logic              dc_req_ready;
    logic [ADDR_W-1:0] dc_req_addr;
    logic              dc_req_rw;
    logic              dc_req_data_valid;
    logic              dc_req_data_ready;
    logic [DATA_W-1:0] dc_req_data_bits;
    logic [MASK_W-1:0] dc_req_data_mask;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_rw;
    logic              mem_req_data_valid;
    logic              mem_req_data_ready;
    logic [DATA_W-1:0] mem_req_data_bits;
    logic [MASK_W-1:0] mem_req_data_mask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_addr, dc_req_rw,
        input  dc_req_data_valid, dc_req_data_bits,
        input  dc_req_data_mask,
        output dc_req_ready, dc_req_data_ready,
        output dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_rw,
        output mem_req_data_valid, mem_req_data_bits,
        output mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready,
        input  mem_resp_valid, mem_resp_data
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_addr, dc_req_rw,
        output dc_req_data_valid, dc_req_data_bits,
        output dc_req_data_mask,
        input  dc_req_ready, dc_req_data_ready,
        input  dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_rw,
        input  mem_req_data_valid, mem_req_data_bits,
        input  mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready,
        output mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/mem_arb_grant.sv
// Grant select between the two qualified client requests.
// ARB_RR_EN: tie goes to the client not granted last; otherwise dcache wins.
module mem_arb_grant (
`ifdef ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic accept,
`endif
    input  logic ic_req,
    input  logic dc_req,
    output logic gnt_ic,
    output logic gnt_dc
);

`ifdef ARB_RR_EN
    // 0 = icache granted last, so dcache wins the first tie
    logic last_dc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_dc <= 1'b0;
        end else if (accept) begin
            last_dc <= gnt_dc;
        end
    end

    always_comb begin
        gnt_dc = dc_req && (!ic_req || !last_dc);
        gnt_ic = ic_req && !gnt_dc;
    end
`else
    always_comb begin
        gnt_dc = dc_req;
        gnt_ic = ic_req && !dc_req;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Icache/dcache to main-memory arbiter: one beat transaction at a time,
// read ownership held until all response beats return. Option: ARB_RR_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RESP_BEATS = DEF_RESP_BEATS
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (RESP_BEATS > 1) ? $clog2(RESP_BEATS) : 1;

    state_t            state;
    state_t            state_nx;
    owner_t            owner;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_rw;
    logic [DATA_W-1:0] wr_data;
    logic [MASK_W-1:0] wr_mask;
    logic              cmd_pend;
    logic              data_pend;
    logic [CNT_W-1:0]  beat_cnt;

    logic idle;
    logic ic_q;
    logic dc_q;
    logic gnt_ic;
    logic gnt_dc;
    logic accept;
    logic cmd_done;
    logic data_done;
    logic beat;
    logic last_beat;
    logic dc_wr;

    assign idle   = (state == IDLE);
    assign dc_wr  = bus.dc_req_rw;
    assign ic_q   = idle && bus.ic_req_valid;
    // a write only competes once its data beat is also presented
    assign dc_q   = idle && bus.dc_req_valid
                  && (!dc_wr || bus.dc_req_data_valid);
    assign accept = gnt_ic || gnt_dc;

    mem_arb_grant u_grant (
`ifdef ARB_RR_EN
        .clk    (clk),
        .reset  (reset),
        .accept (accept),
`endif
        .ic_req (ic_q),
        .dc_req (dc_q),
        .gnt_ic (gnt_ic),
        .gnt_dc (gnt_dc)
    );

    assign cmd_done  = !cmd_pend || bus.mem_req_ready;
    assign data_done = !data_pend || bus.mem_req_data_ready;
    assign beat      = (state == RESP) && bus.mem_resp_valid;
    assign last_beat = beat
                     && (beat_cnt == CNT_W'(RESP_BEATS - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx              = state;
        bus.ic_req_ready      = 1'b0;
        bus.dc_req_ready      = 1'b0;
        bus.dc_req_data_ready = 1'b0;
        bus.ic_resp_valid     = 1'b0;
        bus.dc_resp_valid     = 1'b0;
        unique case (state)
            IDLE: begin
                bus.ic_req_ready      = gnt_ic;
                bus.dc_req_ready      = gnt_dc;
                bus.dc_req_data_ready = gnt_dc && dc_wr;
                if (accept) state_nx = ISSUE;
            end
            ISSUE: begin
                if (cmd_done && data_done) begin
                    state_nx = cmd_rw ? IDLE : RESP;
                end
            end
            RESP: begin
                bus.ic_resp_valid = bus.mem_resp_valid
                                  && (owner == OWN_IC);
                bus.dc_resp_valid = bus.mem_resp_valid
                                  && (owner == OWN_DC);
                if (last_beat) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner     <= OWN_NONE;
            cmd_addr  <= '0;
            cmd_rw    <= 1'b0;
            wr_data   <= '0;
            wr_mask   <= '0;
            cmd_pend  <= 1'b0;
            data_pend <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            if (accept) begin
                owner     <= gnt_dc ? OWN_DC : OWN_IC;
                cmd_addr  <= gnt_dc ? bus.dc_req_addr
                                    : bus.ic_req_addr;
                cmd_rw    <= gnt_dc && dc_wr;
                wr_data   <= (gnt_dc && dc_wr)
                           ? bus.dc_req_data_bits : '0;
                wr_mask   <= (gnt_dc && dc_wr)
                           ? bus.dc_req_data_mask : '0;
                cmd_pend  <= 1'b1;
                data_pend <= gnt_dc && dc_wr;
            end else begin
                if (cmd_pend && bus.mem_req_ready) begin
                    cmd_pend <= 1'b0;
                end
                if (data_pend && bus.mem_req_data_ready) begin
                    data_pend <= 1'b0;
                end
            end
            if (beat) begin
                beat_cnt <= last_beat ? '0
                                      : beat_cnt + CNT_W'(1);
            end
            if (last_beat
                || (state == ISSUE && state_nx == IDLE)) begin
                owner <= OWN_NONE;
            end
        end
    end

    assign bus.mem_req_valid      = cmd_pend;
    assign bus.mem_req_addr       = cmd_addr;
    assign bus.mem_req_rw         = cmd_rw;
    assign bus.mem_req_data_valid = data_pend;
    assign bus.mem_req_data_bits  = wr_data;
    assign bus.mem_req_data_mask  = wr_mask;
    assign bus.ic_resp_data       = bus.mem_resp_data;
    assign bus.dc_resp_data       = bus.mem_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cache/memory traffic,
// expected commands and response beats queued at issue, checked by a monitor.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic          rw;
    } cmd_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RESP_BEATS(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    cmd_t          exp_cmd[$];
    logic [DW-1:0] exp_wd[$];
    logic [MW-1:0] exp_wm[$];
    logic [DW-1:0] exp_ic[$];
    logic [DW-1:0] exp_dc[$];
    cmd_t          mc;
    logic [DW-1:0] md;

    task automatic chk(string nm, logic [127:0] act,
                       logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            if (exp_cmd.size() == 0) begin
                chk("cmd_unexpected", 1, 0);
            end else begin
                mc = exp_cmd.pop_front();
                chk("cmd_addr", bus.mem_req_addr, mc.addr);
                chk("cmd_rw", bus.mem_req_rw, mc.rw);
            end
        end
        if (bus.mem_req_data_valid && bus.mem_req_data_ready) begin
            if (exp_wd.size() == 0) begin
                chk("wdata_unexpected", 1, 0);
            end else begin
                chk("wdata", bus.mem_req_data_bits,
                    exp_wd.pop_front());
                chk("wmask", bus.mem_req_data_mask,
                    exp_wm.pop_front());
            end
        end
        if (bus.ic_resp_valid) begin
            if (exp_ic.size() == 0) begin
                chk("ic_resp_unexpected", 1, 0);
            end else begin
                md = exp_ic.pop_front();
                chk("ic_resp_data", bus.ic_resp_data, md);
            end
        end
        if (bus.dc_resp_valid) begin
            if (exp_dc.size() == 0) begin
                chk("dc_resp_unexpected", 1, 0);
            end else begin
                md = exp_dc.pop_front();
                chk("dc_resp_data", bus.dc_resp_data, md);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(logic [AW-1:0] a, logic rw);
        cmd_t c;
        c.addr = a;
        c.rw   = rw;
        exp_cmd.push_back(c);
    endtask

    task automatic push_beats(logic [DW-1:0] base, int n,
                              logic to_dc);
        for (int i = 0; i < n; i++) begin
            if (to_dc) exp_dc.push_back(base + DW'(i));
            else       exp_ic.push_back(base + DW'(i));
        end
    endtask

    task automatic ic_req(input logic [AW-1:0] a,
                          output int acc);
        acc = -1;
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = a;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.ic_req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("ic_accept_timeout", 0, 1);
        tick();
        bus.ic_req_valid = 1'b0;
    endtask

    task automatic dc_req(input logic [AW-1:0] a,
                          input logic rw,
                          input logic [DW-1:0] d,
                          input logic [MW-1:0] m,
                          output int acc);
        acc = -1;
        bus.dc_req_valid      = 1'b1;
        bus.dc_req_addr       = a;
        bus.dc_req_rw         = rw;
        bus.dc_req_data_valid = rw;
        bus.dc_req_data_bits  = d;
        bus.dc_req_data_mask  = m;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.dc_req_ready) begin
                acc = cyc;
                chk("dc_data_ready_pulse",
                    bus.dc_req_data_ready, rw);
                break;
            end
        end
        if (acc < 0) chk("dc_accept_timeout", 0, 1);
        tick();
        bus.dc_req_valid      = 1'b0;
        bus.dc_req_data_valid = 1'b0;
    endtask

    // memory side of one read: immediate command ready, nb beats
    task automatic mem_rd(input logic [DW-1:0] base,
                          input int gap, input int nb,
                          output int cmd_c, output int last_c);
        cmd_c  = -1;
        last_c = -1;
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.mem_req_valid) begin
                cmd_c = cyc;
                break;
            end
        end
        if (cmd_c < 0) chk("mem_cmd_timeout", 0, 1);
        tick();
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < nb; b++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = base + DW'(b);
            @(negedge clk);
            last_c = cyc;
            tick();
            bus.mem_resp_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, "_mem_valid"}, bus.mem_req_valid, 0);
        chk({nm, "_mem_dvalid"}, bus.mem_req_data_valid, 0);
        chk({nm, "_ic_ready"}, bus.ic_req_ready, 0);
        chk({nm, "_dc_ready"}, bus.dc_req_ready, 0);
        chk({nm, "_dc_dready"}, bus.dc_req_data_ready, 0);
        chk({nm, "_ic_resp"}, bus.ic_resp_valid, 0);
        chk({nm, "_dc_resp"}, bus.dc_resp_valid, 0);
        chk({nm, "_mem_addr"}, bus.mem_req_addr, 0);
    endtask

    task automatic chk_drained(string nm);
        chk({nm, "_cmd_q"}, exp_cmd.size(), 0);
        chk({nm, "_wr_q"}, exp_wd.size(), 0);
        chk({nm, "_ic_q"}, exp_ic.size(), 0);
        chk({nm, "_dc_q"}, exp_dc.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    int ic_acc, dc_acc, cmd_c, last_c, tmp_a;
    int lb[3];
    logic [DW-1:0] wdat;

    initial begin
        bus.ic_req_valid       = 1'b0;
        bus.ic_req_addr        = '0;
        bus.dc_req_valid       = 1'b0;
        bus.dc_req_addr        = '0;
        bus.dc_req_rw          = 1'b0;
        bus.dc_req_data_valid  = 1'b0;
        bus.dc_req_data_bits   = '0;
        bus.dc_req_data_mask   = '0;
        bus.mem_req_ready      = 1'b0;
        bus.mem_req_data_ready = 1'b0;
        bus.mem_resp_valid     = 1'b0;
        bus.mem_resp_data      = '0;
        wdat = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

        repeat (3) tick();
        @(negedge clk);
        chk_all_zero("reset");
        tick();
        reset = 1'b1;
        tick();

        // icache read, immediate ready, back-to-back beats
        push_cmd(28'h0000010, 1'b0);
        push_beats(128'hA, 4, 1'b0);
        fork
            ic_req(28'h0000010, ic_acc);
            mem_rd(128'hA, 0, 4, cmd_c, last_c);
        join
        chk("ic_rd_latency", cmd_c, ic_acc + 1);
        chk_drained("ic_rd");

        // dcache write, data ready three cycles late
        push_cmd(28'h00000FF, 1'b1);
        exp_wd.push_back(wdat);
        exp_wm.push_back(16'hFFFF);
        fork
            dc_req(28'h00000FF, 1'b1, wdat, 16'hFFFF, dc_acc);
            begin
                bus.mem_req_ready = 1'b1;
                cmd_c = -1;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (bus.mem_req_valid) begin
                        cmd_c = cyc;
                        break;
                    end
                end
                if (cmd_c < 0) chk("wr_cmd_timeout", 0, 1);
                chk("wr_dvalid_with_cmd",
                    bus.mem_req_data_valid, 1);
                tick();
                bus.mem_req_ready = 1'b0;
                @(negedge clk);
                chk("wr_cmd_dropped", bus.mem_req_valid, 0);
                chk("wr_data_held", bus.mem_req_data_valid, 1);
                tick();
                tick();
                bus.mem_req_data_ready = 1'b1;
                @(negedge clk);
                tick();
                bus.mem_req_data_ready = 1'b0;
                @(negedge clk);
                chk("wr_data_dropped", bus.mem_req_data_valid, 0);
                chk("wr_no_cmd", bus.mem_req_valid, 0);
            end
        join
        chk("wr_latency", cmd_c, dc_acc + 1);
        tick();
        chk_drained("dc_wr");

        // simultaneous reads; dcache keeps asking for a second line
`ifdef ARB_RR_EN
        push_cmd(28'h20, 1'b0);
        push_cmd(28'h30, 1'b0);
        push_cmd(28'h21, 1'b0);
        push_beats(128'h100, 4, 1'b1);
        push_beats(128'h200, 4, 1'b0);
        push_beats(128'h300, 4, 1'b1);
`else
        push_cmd(28'h20, 1'b0);
        push_cmd(28'h21, 1'b0);
        push_cmd(28'h30, 1'b0);
        push_beats(128'h100, 4, 1'b1);
        push_beats(128'h200, 4, 1'b1);
        push_beats(128'h300, 4, 1'b0);
`endif
        fork
            ic_req(28'h30, ic_acc);
            begin
                dc_req(28'h20, 1'b0, '0, '0, dc_acc);
                dc_req(28'h21, 1'b0, '0, '0, tmp_a);
            end
            begin
                mem_rd(128'h100, 0, 4, cmd_c, lb[0]);
                mem_rd(128'h200, 0, 4, cmd_c, lb[1]);
                mem_rd(128'h300, 0, 4, cmd_c, lb[2]);
            end
        join
`ifdef ARB_RR_EN
        chk("tie_ic_accept", ic_acc, lb[0] + 1);
`else
        chk("tie_ic_accept", ic_acc, lb[1] + 1);
`endif
        chk_drained("tie");

        // stray beat in IDLE, then gapped beats
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 128'hDEAD;
        @(negedge clk);
        chk("stray_ic_resp", bus.ic_resp_valid, 0);
        chk("stray_dc_resp", bus.dc_resp_valid, 0);
        tick();
        bus.mem_resp_valid = 1'b0;
        push_cmd(28'h40, 1'b0);
        push_beats(128'h11, 4, 1'b0);
        fork
            ic_req(28'h40, ic_acc);
            mem_rd(128'h11, 2, 4, cmd_c, last_c);
        join
        chk_drained("gapped");

        // reset after the second beat of a read
        push_cmd(28'h50, 1'b0);
        push_beats(128'h21, 2, 1'b0);
        fork
            ic_req(28'h50, ic_acc);
            mem_rd(128'h21, 0, 2, cmd_c, last_c);
        join
        reset = 1'b0;
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 128'hBAD;
        @(negedge clk);
        chk_all_zero("mid_reset");
        tick();
        bus.mem_resp_valid = 1'b0;
        reset = 1'b1;
        tick();
        push_cmd(28'h60, 1'b0);
        push_beats(128'h31, 4, 1'b0);
        fork
            ic_req(28'h60, ic_acc);
            mem_rd(128'h31, 0, 4, cmd_c, last_c);
        join
        chk_drained("post_reset");

        // dcache write held back until its data is valid
        push_cmd(28'h77, 1'b1);
        exp_wd.push_back(128'hCAFE);
        exp_wm.push_back(16'h00F0);
        tick();
        bus.dc_req_valid      = 1'b1;
        bus.dc_req_addr       = 28'h77;
        bus.dc_req_rw         = 1'b1;
        bus.dc_req_data_bits  = 128'hCAFE;
        bus.dc_req_data_mask  = 16'h00F0;
        bus.dc_req_data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nodata_dc_ready", bus.dc_req_ready, 0);
            chk("nodata_dc_dready", bus.dc_req_data_ready, 0);
            tick();
        end
        bus.dc_req_data_valid = 1'b1;
        @(negedge clk);
        chk("data_dc_ready", bus.dc_req_ready, 1);
        chk("data_dc_dready", bus.dc_req_data_ready, 1);
        tick();
        bus.dc_req_valid       = 1'b0;
        bus.dc_req_data_valid  = 1'b0;
        bus.mem_req_ready      = 1'b1;
        bus.mem_req_data_ready = 1'b1;
        @(negedge clk);
        chk("late_wr_cmd", bus.mem_req_valid, 1);
        chk("late_wr_dvalid", bus.mem_req_data_valid, 1);
        tick();
        bus.mem_req_ready      = 1'b0;
        bus.mem_req_data_ready = 1'b0;
        @(negedge clk);
        chk("late_wr_done", bus.mem_req_valid, 0);
        tick();
        chk_drained("late_wr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
